// File: rtl/dummy_iter_mul.sv
// dummy_iter_mul: iterative shift-add multiplier for the ITER execution path.
// It runs one operation at a time and takes exactly WIDTH cycles to finish.
// The result is the low WIDTH bits of the unsigned product a_i*b_i.
//
// Ports:
//   clk_i, rst_i        clock; synchronous active-high reset
//   valid_i / ready_o   operand handshake (ready_o is high only in IDLE)
//   a_i, b_i            multiplicand / multiplier (WIDTH bits)
//   valid_o / ready_i   result handshake (valid_o is high only in DONE)
//   result_o            accumulator; holds the last result while idle
//   busy_o              an operation is outstanding (BUSY or DONE)
module dummy_iter_mul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The last-iteration test looks at the pre-increment count. When WIDTH is a
  // power of two, WIDTH-1 is all ones and the counter would wrap on the
  // increment that follows.
  logic last_iter;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // The handshake outputs come from state only. This keeps ready_o
  // independent of valid_i and valid_o independent of ready_i.
  assign ready_o  = (state_q == S_IDLE);
  assign valid_o  = (state_q == S_DONE);
  assign busy_o   = (state_q != S_IDLE);
  assign result_o = acc_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Each cycle handles one multiplier bit. The sum is truncated
        // to WIDTH bits, so the carry is dropped.
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) state_d = S_DONE;
      end
      S_DONE: begin
        // No new operation is accepted in this cycle. The next operation
        // can only be accepted once the unit is back in IDLE.
        if (ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dummy_iter_mul.sv
// Bench for dummy_iter_mul. It instantiates a WIDTH=8 unit and a WIDTH=32 unit.
// A cycle-level model, written in terms of accept time and product arithmetic,
// is checked against the 8-bit unit on every cycle. Directed tests add literal
// checks for latency and results.
module tb_dummy_iter_mul;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;

  logic        v8, rdy8, val8, rdyi8, busy8;
  logic [7:0]  a8, b8, res8;
  logic        v32, rdy32, val32, rdyi32, busy32;
  logic [31:0] a32, b32, res32;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dummy_iter_mul #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .valid_i(v8), .ready_o(rdy8), .a_i(a8), .b_i(b8),
    .valid_o(val8), .ready_i(rdyi8), .result_o(res8), .busy_o(busy8));

  dummy_iter_mul #(.WIDTH(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .valid_i(v32), .ready_o(rdy32), .a_i(a32), .b_i(b32),
    .valid_o(val32), .ready_i(rdyi32), .result_o(res32), .busy_o(busy32));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model of the 8-bit unit.
  // ph: 0 = idle, 1 = computing, 2 = result offered.
  // left counts the compute cycles that remain. res is the value result_o
  // must show whenever the unit is not computing.
  int         m_ph = 0;
  int         m_left = 0;
  logic [7:0] m_pend = '0;
  logic [7:0] m_res = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph  <= 0;
      m_res <= '0;
    end else begin
      case (m_ph)
        0: if (v8) begin
             m_ph   <= 1;
             m_left <= 8;
             m_pend <= 8'((int'(a8) * int'(b8)) % 256);
           end
        1: begin
             m_left <= m_left - 1;
             if (m_left == 1) begin
               m_ph  <= 2;
               m_res <= m_pend;
             end
           end
        default: if (rdyi8) m_ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready8", rdy8, m_ph == 0);
      chk("m_valid8", val8, m_ph == 2);
      chk("m_busy8",  busy8, m_ph != 0);
      if (m_ph != 1) chk("m_result8", res8, m_res);
    end
  end

  // This task is called just after a negedge. It waits for valid8 and
  // returns how many rising edges occurred since the accept edge.
  task automatic wait_val8(output int n);
    n = 0;
    while (!val8 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  // This task runs one operation on the 8-bit unit. If stall is nonzero,
  // ready_i is held low for that many cycles after valid_o. During the stall,
  // a second request is presented, and the unit must ignore it.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp,
                     input int stall, input string nm);
    int n;
    @(negedge clk);
    chk({nm, "_ready_before"}, rdy8, 1);
    v8 = 1; a8 = a; b8 = b; rdyi8 = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    v8 = 0;
    wait_val8(n);
    chk({nm, "_latency"}, n, 8);
    chk({nm, "_result"}, res8, exp);
    for (int i = 0; i < stall; i++) begin
      v8 = 1; a8 = 8'd1; b8 = 8'd1;
      @(negedge clk);
      chk({nm, "_stall_valid"}, val8, 1);
      chk({nm, "_stall_result"}, res8, exp);
    end
    v8 = 0; rdyi8 = 1;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_ready_after"}, rdy8, 1);
    chk({nm, "_hold_result"}, res8, exp);
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1; v8 = 0; a8 = '0; b8 = '0; rdyi8 = 1;
    v32 = 0; a32 = '0; b32 = '0; rdyi32 = 1;
    repeat (2) @(negedge clk);
    chk("rst_ready8", rdy8, 1);
    chk("rst_valid8", val8, 0);
    chk("rst_busy8",  busy8, 0);
    chk("rst_result8", res8, 0);
    chk("rst_ready32", rdy32, 1);
    chk("rst_result32", res32, 0);
    rst = 0;
    chk_en = 1;

    // Basic products and edge cases.
    op8(8'd7,   8'd9,   8'd63,  0, "t1_7x9");
    op8(8'd200, 8'd3,   8'd88,  0, "t2_200x3");
    op8(8'd0,   8'd255, 8'd0,   0, "t2_0x255");
    op8(8'd255, 8'd1,   8'd255, 0, "t2_255x1");
    op8(8'd255, 8'd255, 8'd1,   0, "t2_255x255");

    // Backpressure with an ignored request during the stall.
    op8(8'd5, 8'd6, 8'd30, 10, "t4_stall");

    // WIDTH=32 all-ones square.
    @(negedge clk);
    v32 = 1; a32 = '1; b32 = '1;
    @(posedge clk);
    @(negedge clk);
    v32 = 0;
    n = 0;
    while (!val32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t3_latency32", n, 32);
    chk("t3_result32", res32, 32'h0000_0001);
    @(posedge clk);
    @(negedge clk);
    chk("t3_ready32_after", rdy32, 1);

    // Reset in the middle of an operation.
    @(negedge clk);
    v8 = 1; a8 = 8'd7; b8 = 8'd9;
    @(posedge clk);
    @(negedge clk);
    v8 = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t5_ready", rdy8, 1);
    chk("t5_valid", val8, 0);
    chk("t5_busy", busy8, 0);
    chk("t5_result", res8, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (val8) seen = 1;
    end
    chk("t5_no_valid_after_rst", seen, 0);

    // Back-to-back operations with valid_i held high throughout.
    @(negedge clk);
    v8 = 1; a8 = 8'd3; b8 = 8'd4; rdyi8 = 1;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'd2; b8 = 8'd2;
    wait_val8(n);
    chk("t6_lat1", n, 8);
    chk("t6_res1", res8, 12);
    @(posedge clk);
    @(negedge clk);
    chk("t6_ready_gap", rdy8, 1);
    // One edge for the re-accept, then eight compute edges.
    n = 0;
    while (!val8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_lat2", n, 9);
    chk("t6_res2", res8, 4);
    v8 = 0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_ready_end", rdy8, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
